// File: rtl/button_debouncer.sv
// N-channel button conditioner: synchronise, normalise polarity, debounce, press/release/auto-repeat pulses.
// Latency SYNC_STAGES+THRESH clocks pin-to-output; no backpressure, outputs are free-running levels and pulses.
module button_debouncer #(
  parameter int N_BTN         = 4,
  parameter int THRESH        = 10,
  parameter int SYNC_STAGES   = 2,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button_in,
  input  logic             repeat_en,
  output logic [N_BTN-1:0] level_out,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             any_pressed
);

  localparam int CW   = $clog2(THRESH);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(THRESH - 1);
  localparam logic [RW-1:0] RPT_DLY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PER  = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RPT_MAX  = RW'(RMAX);
  localparam logic          PIN_IDLE = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_BTN-1:0] lvl_nxt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          rpt_q, rpt_d;
    logic                   arm_q, arm_d;
    logic                   lvl_q, lvl_d;
    logic                   prs_q, prs_d;
    logic                   rel_q, rel_d;

    // Reset loads the released pin level so a held button is seen as a fresh edge.
    always_ff @(posedge clk) begin
      if (rst) sync_q <= {SYNC_STAGES{PIN_IDLE}};
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], button_in[i]};
    end

    assign s = sync_q[SYNC_STAGES-1] ^ PIN_IDLE;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rpt_q   <= '0;
        arm_q   <= 1'b0;
        lvl_q   <= 1'b0;
        prs_q   <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rpt_q   <= rpt_d;
        arm_q   <= arm_d;
        lvl_q   <= lvl_d;
        prs_q   <= prs_d;
        rel_q   <= rel_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rpt_d   = rpt_q;
      arm_d   = arm_q;
      lvl_d   = lvl_q;
      prs_d   = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        IDLE: begin
          lvl_d = 1'b0;
          if (s) begin
            state_d = PRESS_WAIT;
            cnt_d   = CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            lvl_d   = 1'b1;
            prs_d   = 1'b1;
            rpt_d   = '0;
            arm_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CW'(1);
          end else if (!repeat_en) begin
            rpt_d = '0;
            arm_d = 1'b0;
          end else if (arm_q ? (rpt_q == RPT_PER) : (rpt_q == RPT_DLY)) begin
            // arm_q separates the initial delay from the steady repeat period
            prs_d = 1'b1;
            rpt_d = '0;
            arm_d = 1'b1;
          end else if (rpt_q != RPT_MAX) begin
            rpt_d = rpt_q + RW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            lvl_d   = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          lvl_d   = 1'b0;
        end
      endcase
    end

    assign lvl_nxt[i]       = lvl_d;
    assign level_out[i]     = lvl_q;
    assign press_pulse[i]   = prs_q;
    assign release_pulse[i] = rel_q;
  end

  // Built from next-state levels so it updates on the same edge as level_out.
  always_ff @(posedge clk) begin
    if (rst) any_pressed <= 1'b0;
    else     any_pressed <= |lvl_nxt;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus queues expected pulse events, a monitor checks them.
module tb_button_debouncer;
  localparam int TH  = 4;
  localparam int SS  = 2;
  localparam int RD  = 5;
  localparam int RP  = 3;
  localparam int LAT = SS + TH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] button_in = 4'hF;
  logic       repeat_en = 1'b0;
  logic [3:0] level_out, press_pulse, release_pulse;
  logic       any_pressed;

  button_debouncer #(
    .N_BTN(4), .THRESH(TH), .SYNC_STAGES(SS), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .button_in(button_in), .repeat_en(repeat_en),
    .level_out(level_out), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lvl;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.at = at; e.prs = p; e.rel = r; e.lvl = l;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic press_set(input logic [3:0] pressed);
    button_in = ~pressed;
  endtask

  // Monitor: every pulse cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if ((press_pulse | release_pulse) !== 4'b0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: press=%b release=%b at cycle %0d, none expected",
                 press_pulse, release_pulse, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("ev_cycle",   cyc,           e.at);
        check("ev_press",   press_pulse,   e.prs);
        check("ev_release", release_pulse, e.rel);
        check("ev_level",   level_out,     e.lvl);
        check("ev_any",     any_pressed,   |e.lvl);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    int c;
    int a;
    int offs[5];
    offs = '{5, 8, 11, 14, 17};

    idle(3);
    check("rst_level",   level_out,     4'h0);
    check("rst_press",   press_pulse,   4'h0);
    check("rst_release", release_pulse, 4'h0);
    check("rst_any",     any_pressed,   1'b0);
    rst = 1'b0;
    idle(5);

    // clean press on ch0
    c = cyc;
    press_set(4'b0001);
    push(c + LAT, 4'b0001, 4'b0000, 4'b0001);
    wait_until(c + LAT - 1);
    check("press_not_early", level_out, 4'b0000);
    wait_until(c + LAT);
    check("press_level", level_out, 4'b0001);
    check("press_any", any_pressed, 1'b1);
    idle(6);

    // 3-cycle release glitch on ch0 is filtered, then a real release
    press_set(4'b0000);
    idle(3);
    press_set(4'b0001);
    idle(10);
    check("glitch_level", level_out, 4'b0001);
    c = cyc;
    press_set(4'b0000);
    push(c + LAT, 4'b0000, 4'b0001, 4'b0000);
    idle(12);
    check("release_level", level_out, 4'b0000);

    // bounce on ch1: 2-cycle excursions never qualify
    for (int i = 0; i < 5; i++) begin
      press_set(4'b0010);
      idle(2);
      press_set(4'b0000);
      idle(2);
    end
    check("bounce_level", level_out, 4'b0000);
    c = cyc;
    press_set(4'b0010);
    push(c + LAT, 4'b0010, 4'b0000, 4'b0010);
    idle(12);
    c = cyc;
    press_set(4'b0000);
    push(c + LAT, 4'b0000, 4'b0010, 4'b0000);
    idle(12);

    // auto-repeat on ch2
    repeat_en = 1'b1;
    c = cyc;
    press_set(4'b0100);
    a = c + LAT;
    push(a, 4'b0100, 4'b0000, 4'b0100);
    for (int i = 0; i < 5; i++) push(a + offs[i], 4'b0100, 4'b0000, 4'b0100);
    wait_until(a + 19);
    repeat_en = 1'b0;
    idle(30);
    check("repeat_hold_level", level_out, 4'b0100);
    c = cyc;
    press_set(4'b0000);
    push(c + LAT, 4'b0000, 4'b0100, 4'b0000);
    idle(12);

    // all channels together
    c = cyc;
    press_set(4'b1111);
    push(c + LAT, 4'b1111, 4'b0000, 4'b1111);
    idle(12);
    check("all_level", level_out, 4'b1111);
    c = cyc;
    press_set(4'b0000);
    push(c + LAT, 4'b0000, 4'b1111, 4'b0000);
    idle(12);

    // reset while ch3 is held
    c = cyc;
    press_set(4'b1000);
    push(c + LAT, 4'b1000, 4'b0000, 4'b1000);
    idle(12);
    rst = 1'b1;
    idle(1);
    check("midrst_level",   level_out,     4'h0);
    check("midrst_any",     any_pressed,   1'b0);
    check("midrst_press",   press_pulse,   4'h0);
    check("midrst_release", release_pulse, 4'h0);
    idle(2);
    c = cyc;
    rst = 1'b0;
    push(c + LAT, 4'b1000, 4'b0000, 4'b1000);
    wait_until(c + LAT - 1);
    check("postrst_not_early", level_out, 4'b0000);
    idle(7);
    check("postrst_level", level_out, 4'b1000);
    c = cyc;
    press_set(4'b0000);
    push(c + LAT, 4'b0000, 4'b1000, 4'b0000);
    idle(12);

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Parametrised N-channel button conditioner that replaces the fixed 4-button debouncer feeding the whack-a-mole game FSM.
- Each channel is synchronised, polarity-normalised and debounced independently by its own counter.
- Each channel outputs a debounced level plus single-cycle press/release pulses.
- Optional auto-repeat regenerates press pulses while a button is held.

Parameters:
- N_BTN, 4, number of independent button channels (>=1).
- THRESH, 10, consecutive stable synchronised samples needed to accept a level change (>=2).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- ACTIVE_LOW, 1, 1 = button_in reads 0 when pressed; 0 = reads 1 when pressed.
- REPEAT_DELAY, 50, cycles in HELD before the first auto-repeat pulse (>=1).
- REPEAT_PERIOD, 20, cycles between subsequent auto-repeat pulses (>=1).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- button_in, input, N_BTN, raw asynchronous button pins.
- repeat_en, input, 1, global auto-repeat enable.
- level_out, output, N_BTN, debounced state per channel; 1 = pressed.
- press_pulse, output, N_BTN, one-cycle pulse on accepted press or auto-repeat.
- release_pulse, output, N_BTN, one-cycle pulse on accepted release.
- any_pressed, output, 1, OR-reduction of level_out (registered).

Behaviour:
- Reset: one clock is synchronous and active-high.
  - level_out, press_pulse, release_pulse and any_pressed are all 0 while rst is high.
  - All channel FSMs go to IDLE; debounce and repeat counters go to 0.
  - Synchroniser flops load the released pin level (1 if ACTIVE_LOW), so no spurious press occurs when reset is released.
- Per-channel sample s: the last synchroniser stage, inverted if ACTIVE_LOW. s = 1 means pressed.
- Per-channel FSM, all outputs registered:
  - IDLE (level 0): s=1 -> PRESS_WAIT, cnt<=1.
  - PRESS_WAIT (level 0):
    - s=0 -> IDLE, cnt<=0, no pulse.
    - s=1 and cnt==THRESH-1 -> HELD; level<=1, press_pulse<=1, rpt<=0.
    - otherwise cnt++.
  - HELD (level 1): s=0 -> RELEASE_WAIT, cnt<=1. Otherwise run the repeat logic below.
  - RELEASE_WAIT (level 1):
    - s=1 -> HELD, cnt<=0, no pulse; rpt keeps its value.
    - s=0 and cnt==THRESH-1 -> IDLE; level<=0, release_pulse<=1.
    - otherwise cnt++.
- Latency: level_out and the pulse become visible after SYNC_STAGES+THRESH rising edges. Edge 1 is the first edge that samples the new pin level. Press and release latencies are identical.
- Glitches: any excursion shorter than THRESH synchronised samples is filtered completely; the count restarts from scratch on the next excursion.
- Auto-repeat, HELD state only:
  - If repeat_en=1, rpt increments every cycle.
  - When rpt==REPEAT_DELAY-1 for the first time, assert press_pulse.
  - After that, assert press_pulse every REPEAT_PERIOD cycles.
  - If repeat_en=0, rpt<=0 and no repeat pulses are issued. Re-enabling restarts the full REPEAT_DELAY.
  - rpt is frozen, and no repeat pulses are issued, while in RELEASE_WAIT.
- Pulses are exactly one cycle wide. press_pulse and release_pulse are never both high on the same channel in the same cycle.
- Channels are fully independent. Simultaneous presses on several channels pulse in the same cycle.
- any_pressed equals the OR of level_out, registered in the same cycle as level_out.
- Counter widths:
  - cnt is clog2(THRESH) bits.
  - rpt is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1) bits.
  - Neither counter may wrap; both saturate at their terminal values.
- Reset mid-operation: a channel that is held through reset deassertion is treated as a fresh press. It gives a full-latency press_pulse after reset, with no release_pulse.

Test Plan:
- Clean press: THRESH=4, SYNC_STAGES=2, ch0 driven 1->0 and held. Expect level_out[0] high after exactly 6 edges, a single press_pulse[0], and any_pressed=1.
- Bounce: ch1 toggles low/high every 2 cycles for 20 cycles, then stays low (THRESH=4). Expect no pulse during the bounce and exactly one press_pulse 6 edges after the final low.
- Release glitch: ch0 held, pin goes high for 3 cycles then low again. Expect no release_pulse and level_out[0] to stay 1. A later 4+ cycle release gives release_pulse 6 edges after that release.
- Auto-repeat: repeat_en=1, REPEAT_DELAY=5, REPEAT_PERIOD=3, ch2 held for 20 cycles after acceptance. Expect press pulses at acceptance, then at +5, +8, +11, +14, +17. Dropping repeat_en stops further pulses.
- Simultaneous: all 4 channels pressed on the same edge. Expect press_pulse=4'b1111 in one cycle and level_out=4'b1111.
- Reset: rst asserted while ch3 is held. Outputs go to 0 on the next edge. After rst is released with ch3 still held, press_pulse[3] fires after SYNC_STAGES+THRESH edges and no release_pulse is seen.
